// File: rtl/dontcare_skid_buffer.sv
// Two-entry valid/ready skid buffer that tolerates x payloads upstream and drives x when idle.
// Latency: one cycle from accept to out_data; in_ready is a pure function of registered state.
// Backpressure: in_ready drops the cycle after the second entry is captured (FULL).
// Optional build macro DONTCARE_ZERO_EN: drive 0 instead of x at every don't-care point.
module dontcare_skid_buffer #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

`ifdef DONTCARE_ZERO_EN
  localparam logic [WIDTH-1:0] DC = '0;
`else
  localparam logic [WIDTH-1:0] DC = 'x;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] xfer_q;
  logic                 accept;
  logic                 emit;

  // Handshakes are qualified only by registered state, so in_data is looked at solely on accept.
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Next-state, datapath selects and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
        case ({accept, emit})
          2'b10: begin
            skid_d  = in_data;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          2'b11: main_d = in_data;
          default: ;
        endcase
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
        if (emit) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and payload registers; payload resets to don't-care (or 0).
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= DC;
      skid_q  <= DC;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Accepted-transfer counter, wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
    end else if (accept) begin
      xfer_q <= xfer_q + CNT_WIDTH'(1);
    end
  end

  assign out_data   = out_valid ? main_q : DC;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_dontcare_skid_buffer.sv
// Bench for dontcare_skid_buffer: directed scenarios plus random traffic vs a 2-deep FIFO model.
// The model treats the buffer as a queue: ready while fewer than two held, head shown on output.
// Per-cycle checks happen on the falling edge; inputs change 1 time unit after the rising edge.
module tb_dontcare_skid_buffer;
  localparam int W = 8;
  localparam int C = 16;

`ifdef DONTCARE_ZERO_EN
  localparam logic [W-1:0] DC = '0;
`else
  localparam logic [W-1:0] DC = 'x;
`endif

  logic         clock = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;
  logic [C-1:0] xfer_count;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic [C-1:0] mcnt = '0;
  bit           chk_en = 1'b1;
  int           xseen = 0;

  always #5 clock = ~clock;

  dontcare_skid_buffer #(.WIDTH(W), .CNT_WIDTH(C)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model.
  task automatic chk_all(input string tag);
    logic [W-1:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : DC;
    chk({tag, ".in_ready"},   32'(q.size() < 2),  32'(in_ready));
    chk({tag, ".out_valid"},  32'(out_valid),     32'(q.size() > 0));
    chk({tag, ".occupancy"},  32'(occupancy),     32'(q.size()));
    chk({tag, ".xfer_count"}, 32'(xfer_count),    32'(mcnt));
    chk({tag, ".out_data"},   32'(out_data),      32'(exp_d));
  endtask

  // One clock: drive inputs, check at falling edge, advance model at the rising edge.
  task automatic cyc(input string tag, input logic v, input logic [W-1:0] d, input logic r);
    logic acc;
    logic emi;
    in_valid  = v;
    in_data   = v ? d : 'x;
    out_ready = r;
    @(negedge clock);
    if (chk_en) chk_all(tag);
    if (out_valid === 1'b1 && $isunknown(out_data)) xseen++;
    acc = v && (q.size() < 2);
    emi = (q.size() > 0) && r;
    @(posedge clock);
    if (emi) void'(q.pop_front());
    if (acc) begin
      q.push_back(d);
      mcnt++;
    end
    #1;
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    mcnt = '0;
    chk_all(tag);
    #3 rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    out_ready = 1'b0;

    // 1: reset state and idle with x on in_data
    #1 chk_all("reset");
    #11 rst_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) cyc("idle", 1'b0, 'x, 1'b1);

    // 2: streaming with downstream always ready
    cyc("s1", 1'b1, 8'h11, 1'b1);
    cyc("s2", 1'b1, 8'h22, 1'b1);
    cyc("s3", 1'b1, 8'h33, 1'b1);
    chk("stream_head", 32'(out_data), 32'h33);
    chk("stream_cnt", 32'(xfer_count), 32'd3);
    cyc("s4", 1'b0, 'x, 1'b1);

    // 3: fill to FULL, then drain
    cyc("f1", 1'b1, 8'hA5, 1'b0);
    cyc("f2", 1'b1, 8'h5A, 1'b0);
    cyc("f3", 1'b1, 8'hEE, 1'b0);  // refused: in_ready is 0
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_rdy", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_data), 32'hA5);
    cyc("d1", 1'b0, 'x, 1'b1);
    chk("drain_rdy", 32'(in_ready), 32'd1);
    chk("drain_head", 32'(out_data), 32'h5A);
    cyc("d2", 1'b0, 'x, 1'b1);
    cyc("d3", 1'b0, 'x, 1'b1);

    // 4: gaps of x between valid beats
    pulse_reset("rst4");
    cyc("g1", 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 5; i++) cyc("gap", 1'b0, 'x, 1'b1);
    cyc("g2", 1'b1, 8'h02, 1'b1);
    cyc("g3", 1'b0, 'x, 1'b1);
    chk("gap_cnt", 32'(xfer_count), 32'd2);

    // 5: reset while FULL, then a fresh transfer
    cyc("c1", 1'b1, 8'hC3, 1'b0);
    cyc("c2", 1'b1, 8'h3C, 1'b0);
    cyc("c3", 1'b0, 'x, 1'b0);
    pulse_reset("rst5");
    cyc("n1", 1'b1, 8'h77, 1'b0);
    cyc("n2", 1'b0, 'x, 1'b0);
    chk("post_rst_data", 32'(out_data), 32'h77);
    chk("post_rst_occ", 32'(occupancy), 32'd1);

    // randomized traffic
    pulse_reset("rstr");
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0));
    end
    chk("no_x_when_valid", 32'(xseen), 32'd0);

    // 6: counter wrap
    pulse_reset("rst6");
    chk_en = 1'b0;
    for (int i = 0; i < 32'hFFFE; i++) cyc("pre", 1'b1, W'(i), 1'b1);
    chk_en = 1'b1;
    cyc("w0", 1'b1, 8'h9A, 1'b1);
    chk("cnt_fffe_plus1", 32'(xfer_count), 32'h0000_FFFF);
    cyc("w1", 1'b1, 8'h9B, 1'b1);
    cyc("w2", 1'b0, 'x, 1'b1);
    chk("cnt_wrap", 32'(xfer_count), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
